// File: rtl/pingpong_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_frame_scheduler_pkg
// Purpose  : Shared state encoding and bank-index constants for the
//            ping-pong frame scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package pingpong_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_SWAP    = 3'd2,
    S_OVERLAP = 3'd3,
    S_DRAIN   = 3'd4,
    S_ERROR   = 3'd5
  } state_e;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pingpong_frame_scheduler_phase_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_frame_scheduler_phase_watchdog
// Purpose  : Per-phase cycle counter; flags when a phase has lasted
//            TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_frame_scheduler_phase_watchdog #(
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int TMR_W          = 23
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  // Clear has priority so the count restarts on every phase entry.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TMR_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/pingpong_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_frame_scheduler
// Purpose  : Sequences a double-buffered camera/processing pipeline: hands
//            out stage enables and bank selects, swaps banks when both stages
//            finish, counts frames, watches each phase for a stall and
//            supports a graceful stop/drain.
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_frame_scheduler
  import pingpong_frame_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int TMR_W          = 23,
  parameter int FCNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear_err,
  input  logic              cam_done,
  input  logic              proc_done,
  output logic              cam_enable,
  output logic              proc_enable,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              busy,
  output logic              timeout_err,
  output logic [FCNT_W-1:0] frame_count,
  output logic              frame_out
);

  state_e             state_q,        state_d;
  logic               wr_bank_q,      wr_bank_d;
  logic               cam_en_q,       cam_en_d;
  logic               proc_en_q,      proc_en_d;
  logic               cam_seen_q,     cam_seen_d;
  logic               proc_seen_q,    proc_seen_d;
  logic               stop_pending_q, stop_pending_d;
  logic               busy_q,         busy_d;
  logic               timeout_err_q,  timeout_err_d;
  logic               frame_out_q,    frame_out_d;
  logic [FCNT_W-1:0]  frame_count_q,  frame_count_d;

  logic w_cam_acc;
  logic w_proc_acc;
  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expired;

  // A done pulse only counts while its stage is actually enabled.
  assign w_cam_acc  = cam_done  & cam_en_q;
  assign w_proc_acc = proc_done & proc_en_q;

  // Restart the watchdog on every state change; run it only in waiting phases.
  assign w_wd_clear  = (state_d != state_q);
  assign w_wd_enable = (state_q == S_FILL) || (state_q == S_OVERLAP) ||
                       (state_q == S_DRAIN);

  pingpong_frame_scheduler_phase_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  // Next-state, enables, bank/frame bookkeeping; phase completion beats timeout.
  always_comb begin
    state_d        = state_q;
    wr_bank_d      = wr_bank_q;
    cam_en_d       = cam_en_q;
    proc_en_d      = proc_en_q;
    cam_seen_d     = cam_seen_q;
    proc_seen_d    = proc_seen_q;
    stop_pending_d = stop_pending_q;
    frame_count_d  = frame_count_q;
    frame_out_d    = w_proc_acc && ((state_q == S_OVERLAP) || (state_q == S_DRAIN));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_FILL;
          wr_bank_d      = BANK0;
          cam_en_d       = 1'b1;
          proc_en_d      = 1'b0;
          stop_pending_d = stop;
        end
      end

      S_FILL: begin
        if (stop) stop_pending_d = 1'b1;
        if (w_cam_acc) begin
          state_d       = S_SWAP;
          cam_en_d      = 1'b0;
          proc_en_d     = 1'b0;
          wr_bank_d     = (wr_bank_q == BANK0) ? BANK1 : BANK0;
          frame_count_d = frame_count_q + FCNT_W'(1);
          cam_seen_d    = 1'b0;
          proc_seen_d   = 1'b0;
        end else if (w_wd_expired) begin
          state_d   = S_ERROR;
          cam_en_d  = 1'b0;
          proc_en_d = 1'b0;
        end
      end

      S_SWAP: begin
        if (stop_pending_q || stop) begin
          state_d        = S_DRAIN;
          stop_pending_d = 1'b1;
          cam_en_d       = 1'b0;
          proc_en_d      = 1'b1;
        end else begin
          state_d   = S_OVERLAP;
          cam_en_d  = 1'b1;
          proc_en_d = 1'b1;
        end
      end

      S_OVERLAP: begin
        if (stop) stop_pending_d = 1'b1;
        if (w_cam_acc) begin
          cam_en_d   = 1'b0;
          cam_seen_d = 1'b1;
        end
        if (w_proc_acc) begin
          proc_en_d   = 1'b0;
          proc_seen_d = 1'b1;
        end
        if ((cam_seen_q || w_cam_acc) && (proc_seen_q || w_proc_acc)) begin
          state_d       = S_SWAP;
          cam_en_d      = 1'b0;
          proc_en_d     = 1'b0;
          wr_bank_d     = (wr_bank_q == BANK0) ? BANK1 : BANK0;
          frame_count_d = frame_count_q + FCNT_W'(1);
          cam_seen_d    = 1'b0;
          proc_seen_d   = 1'b0;
        end else if (w_wd_expired) begin
          state_d   = S_ERROR;
          cam_en_d  = 1'b0;
          proc_en_d = 1'b0;
        end
      end

      S_DRAIN: begin
        if (w_proc_acc) begin
          state_d        = S_IDLE;
          proc_en_d      = 1'b0;
          stop_pending_d = 1'b0;
        end else if (w_wd_expired) begin
          state_d   = S_ERROR;
          cam_en_d  = 1'b0;
          proc_en_d = 1'b0;
        end
      end

      S_ERROR: begin
        if (clear_err) begin
          state_d        = S_IDLE;
          wr_bank_d      = BANK0;
          cam_seen_d     = 1'b0;
          proc_seen_d    = 1'b0;
          stop_pending_d = 1'b0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cam_en_d  = 1'b0;
        proc_en_d = 1'b0;
      end
    endcase

    busy_d        = (state_d != S_IDLE) && (state_d != S_ERROR);
    timeout_err_d = (state_d == S_ERROR);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      wr_bank_q      <= BANK0;
      cam_en_q       <= 1'b0;
      proc_en_q      <= 1'b0;
      cam_seen_q     <= 1'b0;
      proc_seen_q    <= 1'b0;
      stop_pending_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      frame_out_q    <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wr_bank_q      <= wr_bank_d;
      cam_en_q       <= cam_en_d;
      proc_en_q      <= proc_en_d;
      cam_seen_q     <= cam_seen_d;
      proc_seen_q    <= proc_seen_d;
      stop_pending_q <= stop_pending_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      frame_out_q    <= frame_out_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign cam_enable  = cam_en_q;
  assign proc_enable = proc_en_q;
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = ~wr_bank_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign frame_count = frame_count_q;
  assign frame_out   = frame_out_q;

endmodule
`default_nettype wire
